sub_flag_stage: RTL and testbench

SUB_FLAG_STAGE -- requirements
Module: sub_flag_stage

---
 rtl/alu_pkg.sv | 14 +
 rtl/sub_flags.sv | 22 ++
 rtl/sub_flag_stage.sv | 100 ++++++++++
 tb/tb_sub_flag_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand width and {N,Z,B,V} flag bit positions.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int FLAG_W    = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_B = 1;
    localparam int FLAG_V = 0;

    typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/sub_flags.sv
// Derives {N,Z,B,V} from a subtractor result {0,a}-{0,b}; purely combinational.
module sub_flags
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic [WIDTH:0]   y,
    output logic [FLAG_W-1:0] flags
);

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = y[WIDTH-1];
        flags[FLAG_Z] = (y[WIDTH-1:0] == '0);
        flags[FLAG_B] = y[WIDTH];
        // Signed overflow: operands differ in sign and the result sign differs from the minuend.
        flags[FLAG_V] = (a_msb ^ b_msb) & (a_msb ^ y[WIDTH-1]);
    end

endmodule

// File: rtl/sub_flag_stage.sv
// Captures subtractor results with their flags into a 2-entry FIFO and counts signed overflows.
// One-cycle latency from empty; in_ready is registered (count != 2) and never depends on out_ready.
module sub_flag_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [WIDTH:0]     in_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_diff,
    output logic [FLAG_W-1:0]  out_flags,
    output logic [CNT_W-1:0]   ovf_count
);

    localparam int ENT_W = WIDTH + FLAG_W;

    logic [FLAG_W-1:0] in_flags;
    logic              push;
    logic              pop;

    logic [ENT_W-1:0]  mem_q [2];
    logic [ENT_W-1:0]  mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;

    // Only the operand sign bits feed the overflow term.
    logic unused_ok;
    assign unused_ok = ^{in_a[WIDTH-2:0], in_b[WIDTH-2:0]};

    sub_flags #(
        .WIDTH (WIDTH)
    ) u_sub_flags (
        .a_msb (in_a[WIDTH-1]),
        .b_msb (in_b[WIDTH-1]),
        .y     (in_y),
        .flags (in_flags)
    );

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_diff  = mem_q[rd_ptr_q][ENT_W-1:FLAG_W];
    assign out_flags = mem_q[rd_ptr_q][FLAG_W-1:0];
    assign ovf_count = ovf_cnt_q;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_cnt_d = ovf_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = {in_y[WIDTH-1:0], in_flags};
            wr_ptr_d        = ~wr_ptr_q;
            if (in_flags[FLAG_V] && (ovf_cnt_q != {CNT_W{1'b1}}))
                ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
        end

        if (pop)
            rd_ptr_d = ~rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            ovf_cnt_q <= '0;
        end else begin
            mem_q[0]  <= mem_d[0];
            mem_q[1]  <= mem_d[1];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

endmodule

// File: tb/tb_sub_flag_stage.sv
// Directed-vector bench for sub_flag_stage with hand-computed flags, ordering and counter values.
module tb_sub_flag_stage;
    import alu_pkg::*;

    localparam int W = 32;
    localparam int C = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [W:0]    in_y;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_diff;
    logic [3:0]    out_flags;
    logic [C-1:0]  ovf_count;

    int errors = 0;
    int checks = 0;

    sub_flag_stage #(.WIDTH(W), .CNT_W(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_diff  (out_diff),
        .out_flags (out_flags),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] y);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_y     = y;
    endtask

    // Single-result vectors: a, b, y, expected diff, flags {N,Z,B,V}, ovf_count after accept.
    logic [W-1:0] va   [5] = '{32'h00000002, 32'h80000062, 32'h12345678, 32'h00000001, 32'h7FFFFFFF};
    logic [W-1:0] vb   [5] = '{32'hFFFFFFFF, 32'h33FE3783, 32'h12345678, 32'h00000002, 32'hFFFFFFFF};
    logic [W:0]   vy   [5] = '{33'h100000003, 33'h04C01C8DF, 33'h000000000, 33'h1FFFFFFFF, 33'h180000000};
    logic [W-1:0] vd   [5] = '{32'h00000003, 32'h4C01C8DF, 32'h00000000, 32'hFFFFFFFF, 32'h80000000};
    logic [3:0]   vf   [5] = '{4'b0010, 4'b0001, 4'b0100, 4'b1010, 4'b1011};
    logic [C-1:0] vo   [5] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd2};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_y      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_ovf",       ovf_count, 0);
        chk("rst_diff",      out_diff,  0);
        chk("rst_flags",     out_flags, 0);

        // Single results: accept, check head one edge later, then pop.
        for (int i = 0; i < 5; i++) begin
            drive(va[i], vb[i], vy[i]);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_diff", i),  out_diff,  vd[i]);
            chk($sformatf("v%0d_flags", i), out_flags, vf[i]);
            chk($sformatf("v%0d_ovf", i),   ovf_count, vo[i]);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("v%0d_drained", i), out_valid, 0);
        end

        // Empty FIFO with out_ready high must stay empty.
        out_ready = 1'b1;
        tick();
        chk("empty_pop_ignored", out_valid, 0);
        out_ready = 1'b0;

        // Three back-to-back results into a stalled sink.
        drive(32'd10, 32'd1, 33'd9);
        tick();
        chk("bb_ready_after1", in_ready, 1);
        chk("bb_head1", out_diff, 32'd9);
        drive(32'd20, 32'd2, 33'd18);
        tick();
        chk("bb_ready_after2", in_ready, 0);
        drive(32'd30, 32'd3, 33'd27);
        tick();
        chk("bb_ready_held", in_ready, 0);
        chk("bb_head_stable", out_diff, 32'd9);
        chk("bb_valid_stable", out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("bb_out2", out_diff, 32'd18);
        chk("bb_ready_reopen", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bb_out3", out_diff, 32'd27);
        chk("bb_count1_valid", out_valid, 1);
        tick();
        chk("bb_drained", out_valid, 0);
        out_ready = 1'b0;

        // Fill with two overflowing results, then reset mid-stall with in_valid asserted.
        drive(va[1], vb[1], vy[1]);
        tick();
        tick();
        chk("stall_full", in_ready, 0);
        chk("stall_ovf", ovf_count, 8'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_ovf",   ovf_count, 0);
        chk("mid_rst_diff",  out_diff, 0);
        chk("mid_rst_flags", out_flags, 0);
        tick();
        chk("mid_rst_no_accept", out_valid, 0);

        // Saturation: 260 streamed overflowing results with the sink always ready.
        out_ready = 1'b1;
        drive(va[1], vb[1], vy[1]);
        for (int i = 1; i <= 260; i++) begin
            tick();
            if (i == 100) chk("sat_100", ovf_count, 8'd100);
            if (i == 255) chk("sat_255", ovf_count, 8'd255);
        end
        in_valid = 1'b0;
        chk("sat_260", ovf_count, 8'd255);
        tick();
        tick();
        chk("sat_hold", ovf_count, 8'd255);
        chk("sat_drained", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
